// File: rtl/vga_sequencer.sv
// vga_sequencer: frame-synchronous command sequencer for the VGA pixel datapath.
//
// Host commands are queued in a small FIFO. Each command carries a vga_control
// byte and a hold field h. A command is applied on a vsync rising edge (the
// frame tick) and stays on vga_control for h+1 frames. vga_control only changes
// in the cycle after a frame tick, so every byte is stable for whole frames.
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of two, 2..16)
//   AUTO_HOLD   frames per autoplay step (1..255)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   vsync        VGA vertical sync, synchronous to clk
//   cmd_valid    host command offered
//   cmd_data     [7:0] control byte, [11:8] hold field h
//   cmd_ready    FIFO can accept a command (!full)
//   vga_control  [7:6] mode, [5:0] payload
//   busy         a host command is active
//   fifo_count   entries in the FIFO
//
// Build option: define SEQ_AUTOPLAY_EN to step through a demo pattern
// (8'h80..8'h8A) every AUTO_HOLD frames while idle with an empty FIFO.

module vga_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AUTO_HOLD  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        cmd_valid,
  input  logic [11:0] cmd_data,
  output logic        cmd_ready,
  output logic [7:0]  vga_control,
  output logic        busy,
  output logic [4:0]  fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vga_sequencer: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (AUTO_HOLD < 1 || AUTO_HOLD > 255) begin : g_bad_hold
    $error("vga_sequencer: AUTO_HOLD must be in 1..255");
  end

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // Frame tick
  logic vsync_q;
  logic first_q;
  logic frame_tick;

  // FIFO
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [4:0]    count_q, count_d;
  logic          full, empty, push, pop;
  logic [11:0]   head;

  // Sequencer
  state_t      state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [7:0]  vga_q, vga_d;

`ifdef SEQ_AUTOPLAY_EN
  logic [7:0]  div_q, div_d;
  logic [3:0]  step_q, step_d;
`endif

  // first_q masks the tick in the first cycle after reset: vsync_q restarts
  // at 0, so a vsync already high would otherwise look like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
      first_q <= 1'b0;
    end
  end

  assign frame_tick = vsync & ~vsync_q & ~first_q;

  assign full      = (count_q == 5'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Next-state: every update is gated by frame_tick, so vga_control can only
  // move in the cycle after a tick.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vga_d   = vga_q;
    pop     = 1'b0;
`ifdef SEQ_AUTOPLAY_EN
    div_d   = div_q;
    step_d  = step_q;
`endif

    if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            vga_d   = head[7:0];
            rem_d   = head[11:8];
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (rem_q != '0) begin
            rem_d = rem_q - 4'd1;
          end else if (!empty) begin
            pop   = 1'b1;
            vga_d = head[7:0];
            rem_d = head[11:8];
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef SEQ_AUTOPLAY_EN
    // Autoplay only runs in IDLE with nothing queued; a queued command wins
    // the same tick because the divider is held clear while !empty.
    if (state_q == HOLD || !empty) begin
      div_d = '0;
    end else if (frame_tick) begin
      if (div_q == 8'(AUTO_HOLD - 1)) begin
        vga_d  = {2'b10, 2'b00, step_q};
        step_d = (step_q == 4'd10) ? '0 : step_q + 4'd1;
        div_d  = '0;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      vga_q   <= 8'h3F;
`ifdef SEQ_AUTOPLAY_EN
      div_q   <= '0;
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vga_q   <= vga_d;
`ifdef SEQ_AUTOPLAY_EN
      div_q   <= div_d;
      step_q  <= step_d;
`endif
    end
  end

  assign vga_control = vga_q;
  assign busy        = (state_q == HOLD);
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_vga_sequencer.sv
// Bench for vga_sequencer (default build, autoplay disabled).
// A queue-based frame model predicts vga_control/busy/fifo_count/cmd_ready on
// every cycle; directed scenarios add hand-computed literal expectations.

module tb_vga_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        cmd_valid;
  logic [11:0] cmd_data;
  logic        cmd_ready;
  logic [7:0]  vga_control;
  logic        busy;
  logic [4:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  vga_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .AUTO_HOLD (60)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .vga_control(vga_control),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Frame-level model: a command queue plus "frames left" for the active one.
  logic [11:0] mq[$];
  logic [11:0] m_cur;
  bit          m_active = 0;
  int          m_left   = 0;
  logic [7:0]  m_vga    = 8'h3F;
  bit          m_prev   = 0;
  bit          m_fresh  = 1;
  bit          m_valid  = 0;
  bit          m_tick;
  bit          m_accept;
  int          m_size0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 0;
      m_left   = 0;
      m_vga    = 8'h3F;
      m_prev   = 0;
      m_fresh  = 1;
      m_valid  = 1;
    end else begin
      m_tick   = vsync && !m_prev && !m_fresh;
      m_prev   = vsync;
      m_fresh  = 0;
      m_size0  = mq.size();
      m_accept = cmd_valid && (m_size0 < DEPTH);
      if (m_tick) begin
        if (m_active && m_left > 0) begin
          m_left--;
        end else if (m_size0 > 0) begin
          m_cur    = mq.pop_front();
          m_active = 1;
          m_left   = int'(m_cur[11:8]);
          m_vga    = m_cur[7:0];
        end else begin
          m_active = 0;
        end
      end
      if (m_accept) mq.push_back(cmd_data);
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("cyc_vga",   vga_control, m_vga);
      check("cyc_busy",  busy,        m_active);
      check("cyc_count", fifo_count,  mq.size());
      check("cyc_ready", cmd_ready,   mq.size() < DEPTH);
    end
  end

  task automatic tick_frame();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_with_push(input logic [11:0] d);
    @(negedge clk);
    vsync = 1'b1; cmd_valid = 1'b1; cmd_data = d;
    @(negedge clk);
    vsync = 1'b0; cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic push(input logic [11:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_vga", vga_control, 8'h3F);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 1);

    // Idle frames keep the reset byte
    repeat (3) tick_frame();
    check("idle_vga", vga_control, 8'h3F);
    check("idle_busy", busy, 0);

    // Single command h=2 spans 3 frames
    push(12'h205);
    check("p1_count", fifo_count, 1);
    check("p1_vga_pre", vga_control, 8'h3F);
    tick_frame();
    check("p1_vga", vga_control, 8'h05);
    check("p1_busy1", busy, 1);
    check("p1_count0", fifo_count, 0);
    tick_frame();
    tick_frame();
    check("p1_busy3", busy, 1);
    tick_frame();
    check("p1_idle_busy", busy, 0);
    check("p1_idle_vga", vga_control, 8'h05);

    // Fill: 5 offered, 4 accepted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = 12'h011 + 12'(i);
      check("fill_ready", cmd_ready, (i < 4) ? 1 : 0);
    end
    @(negedge clk) cmd_valid = 1'b0;
    check("fill_count", fifo_count, 4);
    check("fill_ready_full", cmd_ready, 0);
    tick_frame();
    check("fill_pop_count", fifo_count, 3);
    check("fill_pop_ready", cmd_ready, 1);
    check("fill_pop_vga", vga_control, 8'h11);
    repeat (3) tick_frame();
    check("drain_vga", vga_control, 8'h14);
    tick_frame();
    check("drain_idle", busy, 0);

    // Full FIFO with a pop in the same cycle still refuses the push
    for (int i = 0; i < 4; i++) push(12'h051 + 12'(i));
    @(negedge clk);
    vsync = 1'b1; cmd_valid = 1'b1; cmd_data = 12'h055;
    check("fullpop_ready", cmd_ready, 0);
    @(negedge clk);
    vsync = 1'b0;
    check("fullpop_count", fifo_count, 3);
    check("fullpop_vga", vga_control, 8'h51);
    @(negedge clk) cmd_valid = 1'b0;
    check("fullpop_refill", fifo_count, 4);
    repeat (5) tick_frame();
    check("fullpop_last", vga_control, 8'h55);
    check("fullpop_idle", busy, 0);

    // Push and pop in the same tick cycle
    push(12'h021);
    push(12'h022);
    tick_with_push(12'h023);
    check("pp_count", fifo_count, 2);
    check("pp_vga", vga_control, 8'h21);
    repeat (2) tick_frame();
    check("pp_vga3", vga_control, 8'h23);
    tick_frame();
    check("pp_idle", busy, 0);

    // Command pushed in the tick cycle into an empty FIFO waits a frame
    tick_with_push(12'h024);
    check("late_vga", vga_control, 8'h23);
    check("late_busy", busy, 0);
    check("late_count", fifo_count, 1);
    tick_frame();
    check("late_vga2", vga_control, 8'h24);
    tick_frame();

    // h=0 then h=1
    push(12'h041);
    push(12'h1C0);
    tick_frame();
    check("seq_a", vga_control, 8'h41);
    tick_frame();
    check("seq_b", vga_control, 8'hC0);
    tick_frame();
    check("seq_b2", vga_control, 8'hC0);
    check("seq_b2_busy", busy, 1);
    tick_frame();
    check("seq_idle", busy, 0);
    check("seq_hold", vga_control, 8'hC0);

    // Reset mid-HOLD with 3 queued; vsync high across reset release
    push(12'h305);
    tick_frame();
    push(12'h031);
    push(12'h032);
    push(12'h033);
    check("mr_count", fifo_count, 3);
    check("mr_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1; vsync = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_vga", vga_control, 8'h3F);
    check("mr_count0", fifo_count, 0);
    check("mr_busy0", busy, 0);
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    check("mr_notick", vga_control, 8'h3F);
    tick_frame();
    check("mr_after_vga", vga_control, 8'h3F);
    check("mr_after_busy", busy, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
